// File: rtl/lsu_dccm_stbuf.sv
// Committed-store buffer in front of the single-ported DCCM write port.
// Optional: define RV_LSU_STBUF_FWD_EN for load forwarding; else hits stall.
module lsu_dccm_stbuf #(
  parameter int DEPTH      = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 39,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst_l,
  input  logic              lsu_freeze_dc3,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  output logic              st_ready,
  input  logic              ld_rden,
  input  logic [ADDR_W-1:0] ld_addr_lo,
  input  logic [ADDR_W-1:0] ld_addr_hi,
  output logic              dccm_wren,
  output logic [ADDR_W-1:0] dccm_wr_addr,
  output logic [DATA_W-1:0] dccm_wr_data,
  output logic              fwd_hit_lo,
  output logic              fwd_hit_hi,
  output logic [DATA_W-1:0] fwd_data_lo,
  output logic [DATA_W-1:0] fwd_data_hi,
  output logic              ld_stall,
  output logic              stbuf_empty,
  output logic              stbuf_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int AW = ADDR_W - 2;
  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {S_NORM, S_FORCE} st_e;

  logic [DEPTH-1:0]  vld_q;
  logic [AW-1:0]     addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       cnt_q;
  logic [SW-1:0]     stv_q, stv_d;
  st_e               state_q, state_d;

  logic              push, pop;
  logic              force_drain, ld_match, starve;
  logic              hit_lo, hit_hi;
  logic [DATA_W-1:0] dlo, dhi;
  logic [PW-1:0]     idx;

  assign stbuf_empty = (cnt_q == '0);
  assign stbuf_full  = (cnt_q == (PW+1)'(DEPTH));
  assign st_ready    = ~stbuf_full;
  assign push        = st_valid & st_ready;
  assign force_drain = (state_q == S_FORCE);
  assign starve      = stbuf_full & ld_rden & ~lsu_freeze_dc3;

  assign dccm_wren    = ~stbuf_empty & ~lsu_freeze_dc3
                      & (~ld_rden | force_drain | ld_match);
  assign pop          = dccm_wren;
  assign dccm_wr_addr = {addr_q[rd_ptr_q], 2'b00};
  assign dccm_wr_data = data_q[rd_ptr_q];
  assign ld_stall     = force_drain | ld_match;

  // Scan oldest to youngest so the last match left standing is the youngest
  always_comb begin
    hit_lo = 1'b0;
    hit_hi = 1'b0;
    dlo    = '0;
    dhi    = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (vld_q[idx] && addr_q[idx] == ld_addr_lo[ADDR_W-1:2]) begin
        hit_lo = 1'b1;
        dlo    = data_q[idx];
      end
      if (vld_q[idx] && addr_q[idx] == ld_addr_hi[ADDR_W-1:2]) begin
        hit_hi = 1'b1;
        dhi    = data_q[idx];
      end
    end
  end

`ifdef RV_LSU_STBUF_FWD_EN
  logic unused_ok;
  assign unused_ok   = ^{st_addr[1:0], ld_addr_lo[1:0], ld_addr_hi[1:0]};
  assign ld_match    = 1'b0;
  assign fwd_hit_lo  = ld_rden & hit_lo;
  assign fwd_hit_hi  = ld_rden & hit_hi;
  assign fwd_data_lo = ld_rden ? dlo : '0;
  assign fwd_data_hi = ld_rden ? dhi : '0;
`else
  logic unused_ok;
  assign unused_ok   = ^{st_addr[1:0], ld_addr_lo[1:0], ld_addr_hi[1:0],
                         dlo, dhi};
  assign ld_match    = ld_rden & (hit_lo | hit_hi);
  assign fwd_hit_lo  = 1'b0;
  assign fwd_hit_hi  = 1'b0;
  assign fwd_data_lo = '0;
  assign fwd_data_hi = '0;
`endif

  // Starvation next-state: count blocked full cycles, then force one drain
  always_comb begin
    state_d = state_q;
    stv_d   = stv_q;
    unique case (state_q)
      S_NORM: begin
        if (starve) begin
          if (stv_q == SW'(STARVE_MAX - 1)) begin
            state_d = S_FORCE;
            stv_d   = '0;
          end else begin
            stv_d = stv_q + 1'b1;
          end
        end else begin
          stv_d = '0;
        end
      end
      S_FORCE: begin
        stv_d = '0;
        if (dccm_wren || stbuf_empty) state_d = S_NORM;
      end
      default: begin
        state_d = S_NORM;
        stv_d   = '0;
      end
    endcase
  end

  // Starvation state register
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q <= S_NORM;
      stv_q   <= '0;
    end else begin
      state_q <= state_d;
      stv_q   <= stv_d;
    end
  end

  // Circular storage: enqueue at wr_ptr, retire head on drain
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      if (pop) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + 1'b1;
      end
      if (push) begin
        vld_q[wr_ptr_q]  <= 1'b1;
        addr_q[wr_ptr_q] <= st_addr[ADDR_W-1:2];
        data_q[wr_ptr_q] <= st_data;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      cnt_q <= cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

endmodule
